// File: rtl/gate_vector_checker_pkg.sv
// Shared types and constants for the gate vector checker: FSM states,
// reference-function encodings and the hold-counter width helper.
package gate_vector_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NAND = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_XNOR = 5;

    // HOLD=1 still needs a one-bit counter to exist.
    function automatic int hold_cnt_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/gvc_ref_model.sv
// Combinational reference: reduction of all vector bits by the selected
// gate function. Unknown OP codes fall back to AND.
module gvc_ref_model
    import gate_vector_checker_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int OP   = OP_AND
) (
    input  logic [N_IN-1:0] vec,
    output logic            expected
);

    always_comb begin
        expected = &vec;
        case (OP)
            OP_AND:  expected = &vec;
            OP_OR:   expected = |vec;
            OP_XOR:  expected = ^vec;
            OP_NAND: expected = ~&vec;
            OP_NOR:  expected = ~|vec;
            OP_XNOR: expected = ~^vec;
            default: expected = &vec;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus-and-check stage for a small combinational gate.
// Define GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN to end the run on the first mismatch.
module gate_vector_checker
    import gate_vector_checker_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int HOLD = 10,
    parameter int OP   = OP_AND
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int            CW        = hold_cnt_width(HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [N_IN:0] ERR_MAX   = (N_IN + 1)'(1) << N_IN;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic          fail_seen;
    logic          expected;
    logic          mismatch;
    logic          last_hold;
    logic          stop_now;

    gvc_ref_model #(
        .N_IN (N_IN),
        .OP   (OP)
    ) u_ref (
        .vec      (vec),
        .expected (expected)
    );

    assign mismatch  = (dut_out != expected);
    assign last_hold = (hold_cnt == HOLD_LAST);

    always_comb begin
        stop_now = &vec;
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
        stop_now = (&vec) | mismatch;
`endif
    end

    // pass is only meaningful once the run has finished
    assign pass = (state == ST_DONE) && (err_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            vec            <= '0;
            hold_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            fail_seen      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_DRIVE;
                        vec            <= '0;
                        hold_cnt       <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        fail_seen      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (last_hold) begin
                        if (mismatch) begin
                            if (err_count != ERR_MAX)
                                err_count <= err_count + (N_IN + 1)'(1);
                            if (!fail_seen) begin
                                fail_seen      <= 1'b1;
                                first_fail_vec <= vec;
                            end
                        end
                        // completion is the all-ones compare; vec never wraps
                        if (stop_now) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec      <= vec + N_IN'(1);
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
